// File: rtl/ford_lamp_pkg.sv
// Shared definitions for the Ford tail-lamp sequence decoder: FSM state codes,
// the seven legal lamp patterns and a state-to-phase helper.
package ford_lamp_pkg;

  typedef logic [2:0] lamp_state_t;

  localparam lamp_state_t ST_IDLE = 3'd0;
  localparam lamp_state_t ST_L1   = 3'd1;
  localparam lamp_state_t ST_L2   = 3'd2;
  localparam lamp_state_t ST_L3   = 3'd3;
  localparam lamp_state_t ST_R1   = 3'd4;
  localparam lamp_state_t ST_R2   = 3'd5;
  localparam lamp_state_t ST_R3   = 3'd6;
  localparam lamp_state_t ST_ERR  = 3'd7;

  // Bit order {LC,LB,LA,RA,RB,RC}; lamps light outward from the centre.
  localparam logic [5:0] PAT_OFF = 6'b000000;
  localparam logic [5:0] PAT_L1  = 6'b001000;
  localparam logic [5:0] PAT_L2  = 6'b011000;
  localparam logic [5:0] PAT_L3  = 6'b111000;
  localparam logic [5:0] PAT_R1  = 6'b000100;
  localparam logic [5:0] PAT_R2  = 6'b000110;
  localparam logic [5:0] PAT_R3  = 6'b000111;

  function automatic logic [1:0] phase_of(input lamp_state_t st);
    logic [1:0] ph;
    ph = 2'd0;
    case (st)
      ST_L1, ST_R1: ph = 2'd1;
      ST_L2, ST_R2: ph = 2'd2;
      ST_L3, ST_R3: ph = 2'd3;
      default:      ph = 2'd0;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/ford_lamp_decoder_if.sv
// Lamp sample inputs and decoded status outputs of the lamp decoder.
// master drives lamps/clr_err (lamp source), slave is the decoder.
interface ford_lamp_decoder_if #(
  parameter int CNT_W = 8
);

  logic [5:0]       lamps;
  logic             clr_err;
  logic             seq_left;
  logic             seq_right;
  logic [1:0]       phase;
  logic             err;
  logic             err_sticky;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output lamps,
    output clr_err,
    input  seq_left,
    input  seq_right,
    input  phase,
    input  err,
    input  err_sticky,
    input  done_cnt
  );

  modport slave (
    input  lamps,
    input  clr_err,
    output seq_left,
    output seq_right,
    output phase,
    output err,
    output err_sticky,
    output done_cnt
  );

endinterface

// File: rtl/ford_sat_counter.sv
// Saturating up-counter: counts inc pulses, holds at all-ones.
// Latency 1 clk from inc to cnt; no backpressure.
module ford_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ford_lamp_decoder.sv
// Decodes the Ford sequential tail-lamp pattern into sequence/phase/error status.
// Latency 1 clk (all outputs registered); no backpressure, lamps sampled every clk.
module ford_lamp_decoder #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  ford_lamp_decoder_if.slave bus
);

  import ford_lamp_pkg::*;

  lamp_state_t      state;
  lamp_state_t      state_nxt;
  logic             ev_left;
  logic             ev_right;
  logic             ev_err;

  logic             seq_left_q;
  logic             seq_right_q;
  logic [1:0]       phase_q;
  logic             err_q;
  logic             err_sticky_q;
  logic [CNT_W-1:0] done_cnt_w;

  logic             is_off;
  logic             is_l1;
  logic             is_l2;
  logic             is_l3;
  logic             is_r1;
  logic             is_r2;
  logic             is_r3;

  assign is_off = (bus.lamps == PAT_OFF);
  assign is_l1  = (bus.lamps == PAT_L1);
  assign is_l2  = (bus.lamps == PAT_L2);
  assign is_l3  = (bus.lamps == PAT_L3);
  assign is_r1  = (bus.lamps == PAT_R1);
  assign is_r2  = (bus.lamps == PAT_R2);
  assign is_r3  = (bus.lamps == PAT_R3);

  // Each active step accepts exactly one successor pattern; anything else,
  // including holding the current pattern, is an error.
  always_comb begin
    state_nxt = state;
    ev_left   = 1'b0;
    ev_right  = 1'b0;
    ev_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (is_off) begin
          state_nxt = ST_IDLE;
        end else if (is_l1) begin
          state_nxt = ST_L1;
        end else if (is_r1) begin
          state_nxt = ST_R1;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_L1: begin
        if (is_l2) begin
          state_nxt = ST_L2;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_L2: begin
        if (is_l3) begin
          state_nxt = ST_L3;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_L3: begin
        if (is_off) begin
          state_nxt = ST_IDLE;
          ev_left   = 1'b1;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_R1: begin
        if (is_r2) begin
          state_nxt = ST_R2;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_R2: begin
        if (is_r3) begin
          state_nxt = ST_R3;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_R3: begin
        if (is_off) begin
          state_nxt = ST_IDLE;
          ev_right  = 1'b1;
        end else begin
          state_nxt = ST_ERR;
          ev_err    = 1'b1;
        end
      end
      ST_ERR: begin
        // Silent until the lamps go dark; no repeated err pulses here.
        if (is_off) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      seq_left_q   <= 1'b0;
      seq_right_q  <= 1'b0;
      phase_q      <= 2'd0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      seq_left_q   <= ev_left;
      seq_right_q  <= ev_right;
      phase_q      <= phase_of(state_nxt);
      err_q        <= ev_err;
      // A fresh error wins over a simultaneous clear.
      err_sticky_q <= ev_err | (err_sticky_q & ~bus.clr_err);
    end
  end

  ford_sat_counter #(
    .WIDTH (CNT_W)
  ) u_done_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (ev_left | ev_right),
    .cnt   (done_cnt_w)
  );

  assign bus.seq_left   = seq_left_q;
  assign bus.seq_right  = seq_right_q;
  assign bus.phase      = phase_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
  assign bus.done_cnt   = done_cnt_w;

endmodule

// File: doc/ford_lamp_decoder.md
FORD_LAMP_DECODER -- requirements
Module: ford_lamp_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of completed-sequence counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port lamps  input  6  tail-lamp pattern {LC,LB,LA,RA,RB,RC}, bit 5 = LC, bit 0 = RC, sampled every clk.
REQ-005 SHALL have port clr_err  input  1  synchronous clear of err_sticky.
REQ-006 SHALL have port seq_left  output  1  one-cycle pulse on completed left sequence.
REQ-007 SHALL have port seq_right  output  1  one-cycle pulse on completed right sequence.
REQ-008 SHALL have port phase  output  2  current step within active sequence (0 = idle, 1..3 = lamps lit).
REQ-009 SHALL have port err  output  1  one-cycle pulse on illegal pattern or transition.
REQ-010 SHALL have port err_sticky  output  1  set by err, held until clr_err.
REQ-011 SHALL have port done_cnt  output  CNT_W  saturating count of completed sequences, both sides.

Function
REQ-012 SHALL decode states IDLE, L1, L2, L3, R1, R2, R3, ERR; all outputs registered, updated on the edge that samples lamps (latency 1 clk).
REQ-013 Legal patterns: OFF=000000, L1=001000, L2=011000, L3=111000, R1=000100, R2=000110, R3=000111.
REQ-014 IDLE: OFF -> IDLE; L1 pattern -> L1; R1 pattern -> R1; any other -> ERR.
REQ-015 L1 -> L2 only on L2 pattern; L2 -> L3 only on L3 pattern; R1/R2 likewise on R2/R3 patterns.
REQ-016 L3 on OFF -> IDLE with seq_left=1 for one cycle; R3 on OFF -> IDLE with seq_right=1 for one cycle.
REQ-017 Any other pattern in L1..L3/R1..R3, including a repeat of the current pattern, SHALL go to ERR.
REQ-018 Entry into ERR SHALL pulse err for exactly one cycle and set err_sticky.
REQ-019 ERR SHALL stay until OFF is sampled, then go to IDLE; no further err pulses while in ERR.
REQ-020 phase SHALL read 0 in IDLE/ERR, k in Lk/Rk.
REQ-021 done_cnt SHALL increment by 1 per seq_left or seq_right pulse and hold at 2^CNT_W-1 (no wrap).
REQ-022 clr_err and new error in the same cycle: err_sticky SHALL remain 1.
REQ-023 seq_left and seq_right SHALL never assert in the same cycle.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, seq_left=0, seq_right=0, phase=0, err=0, err_sticky=0, done_cnt=0.
REQ-025 Reset asserted mid-sequence SHALL abort it without pulse or count; after release, first sample is judged from IDLE.

Structure
REQ-026 Shared package ford_lamp_pkg SHALL hold the state enumeration and the seven lamp pattern constants, for reuse by the encoder FSM and benches.
REQ-027 One sub-module ford_sat_counter (parameter width, inc, saturating) SHALL implement done_cnt.

Verification
REQ-028 Reset released, lamps OFF,L1,L2,L3,OFF -> phase 0,1,2,3,0; seq_left pulse 1 cycle after OFF sample; done_cnt=1.
REQ-029 Lamps OFF,R1,R2,R3,OFF twice back-to-back -> two seq_right pulses; done_cnt=2; err never set.
REQ-030 Lamps L1,L1 -> err pulse on 2nd sample, err_sticky=1; then 111111,OFF -> no second err, state IDLE; clr_err -> err_sticky=0.
REQ-031 Lamps 001100 from IDLE -> err pulse; clr_err asserted same cycle as a new illegal pattern -> err_sticky stays 1.
REQ-032 CNT_W=2, five left sequences -> done_cnt 1,2,3,3,3.
REQ-033 reset_n low while in L2 -> phase=0 asynchronously, no seq_left, done_cnt unchanged at 0; post-release L2 pattern -> err.
